vram_arbiter: RTL and testbench

Shares the single-port video RAM between the display scan and the CPU debug/write port. Uses the sync generator's pixel counters to prefetch the next framebuffer word one word-period ahead. Presents that word to the VGA renderer as a stable `pixel_word`, and serves CPU read/write requests with a req/ack handshake in the remaining slots. Sits between the sync generator, the VGA colour stage and the video RAM.

---
 rtl/vga_pkg.sv | 35 +++
 rtl/vram_arbiter_if.sv | 28 ++
 rtl/vram_fetch_addr.sv | 55 +++++
 rtl/vram_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_vram_arbiter.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared state type and scan-geometry helpers for the video RAM arbiter
package vga_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DISP_RD,
        DISP_CAP,
        CPU_ACC,
        CPU_CAP
    } arb_state_t;

    localparam int V_TOTAL_DEFAULT = 525;

    // log2 of screen pixels covered by one memory word
    function automatic int ppw_log2(input int data_width, input int bits_per_mem_px_x);
        return $clog2(data_width) + bits_per_mem_px_x;
    endfunction

    // screen pixels covered by one memory word
    function automatic int ppw(input int data_width, input int bits_per_mem_px_x);
        return 1 << ppw_log2(data_width, bits_per_mem_px_x);
    endfunction

    // width in screen pixels of the framebuffer area
    function automatic int h_active(input int words_per_row, input int data_width,
                                    input int bits_per_mem_px_x);
        return words_per_row * ppw(data_width, bits_per_mem_px_x);
    endfunction

    // line that follows y, wrapping at the end of the frame
    function automatic logic [9:0] next_line(input logic [9:0] y, input int v_total);
        return (32'(y) == 32'(v_total - 1)) ? 10'd0 : y + 10'd1;
    endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// rtl/vram_arbiter_if.sv - CPU request/ack port and video RAM port bundle
interface vram_arbiter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic                  cpu_ack;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // arbiter side: serves the CPU, drives the RAM
    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        output cpu_ack, cpu_rdata, mem_addr, mem_we, mem_wdata
    );

    // environment side: CPU requester and RAM
    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        input  cpu_ack, cpu_rdata, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/vram_fetch_addr.sv
// rtl/vram_fetch_addr.sv - word-boundary detection and next-word address from the pixel counters
module vram_fetch_addr
    import vga_pkg::*;
#(
    parameter int DATA_WIDTH              = 16,
    parameter int ADDR_WIDTH              = 8,
    parameter int BITS_PER_MEMORY_PIXEL_X = 4,
    parameter int BITS_PER_MEMORY_PIXEL_Y = 4,
    parameter int WORDS_PER_ROW           = 2,
    parameter int ROWS                    = 24,
    parameter int FB_BASE                 = 0,
    parameter int V_TOTAL                 = V_TOTAL_DEFAULT
) (
    input  logic [9:0]            pixel_x,
    input  logic [9:0]            pixel_y,
    output logic [ADDR_WIDTH-1:0] tgt_addr,
    output logic                  tgt_valid,
    output logic                  word_start,
    output logic                  word_end
);

    localparam int PPW_LOG2 = ppw_log2(DATA_WIDTH, BITS_PER_MEMORY_PIXEL_X);
    localparam int PPW      = 1 << PPW_LOG2;
    localparam int H_ACTIVE = h_active(WORDS_PER_ROW, DATA_WIDTH, BITS_PER_MEMORY_PIXEL_X);

    logic [31:0] x_ext;
    logic [31:0] col_cur;
    logic [31:0] tgt_row;
    logic [31:0] tgt_col;
    logic [9:0]  y_next;
    logic        in_active;

    // The target is the word displayed after the current one: the next column on
    // this row, or column 0 of the following line's row. The same target is used
    // for the fetch at the start of a word and the swap at its end, so words
    // outside the displayed rows are neither fetched nor swapped in.
    always_comb begin
        x_ext      = 32'(pixel_x);
        col_cur    = x_ext >> PPW_LOG2;
        y_next     = next_line(pixel_y, V_TOTAL);
        in_active  = x_ext < 32'(H_ACTIVE);
        word_start = in_active && ((x_ext & 32'(PPW - 1)) == 32'd0);
        word_end   = in_active && ((x_ext & 32'(PPW - 1)) == 32'(PPW - 1));
        if (col_cur + 32'd1 < 32'(WORDS_PER_ROW)) begin
            tgt_row = 32'(pixel_y) >> BITS_PER_MEMORY_PIXEL_Y;
            tgt_col = col_cur + 32'd1;
        end else begin
            tgt_row = 32'(y_next) >> BITS_PER_MEMORY_PIXEL_Y;
            tgt_col = 32'd0;
        end
        tgt_valid = tgt_row < 32'(ROWS);
        tgt_addr  = ADDR_WIDTH'(32'(FB_BASE) + tgt_row * 32'(WORDS_PER_ROW) + tgt_col);
    end

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - display-prefetch / CPU arbiter for the single-port video RAM (option: VRAM_ARB_MISS_DETECT_EN)
module vram_arbiter
    import vga_pkg::*;
#(
    parameter int DATA_WIDTH              = 16,
    parameter int ADDR_WIDTH              = 8,
    parameter int BITS_PER_MEMORY_PIXEL_X = 4,
    parameter int BITS_PER_MEMORY_PIXEL_Y = 4,
    parameter int WORDS_PER_ROW           = 2,
    parameter int ROWS                    = 24,
    parameter int FB_BASE                 = 0,
    parameter int V_TOTAL                 = V_TOTAL_DEFAULT
) (
    input  logic                  CLK_50,
    input  logic                  RESET_N,
    input  logic [9:0]            pixel_x,
    input  logic [9:0]            pixel_y,
    vram_arbiter_if.master        bus,
    output logic [DATA_WIDTH-1:0] pixel_word,
    output logic                  fetch_miss
);

    arb_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  mem_we_q, mem_we_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  op_we_q, op_we_d;
    logic                  cpu_ack_q, cpu_ack_d;
    logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
    logic                  shadow_valid_q, shadow_valid_d;
    logic                  disp_pending_q, disp_pending_d;
    logic [ADDR_WIDTH-1:0] disp_addr_q, disp_addr_d;
    logic [DATA_WIDTH-1:0] pixel_word_q, pixel_word_d;
`ifdef VRAM_ARB_MISS_DETECT_EN
    logic                  fetch_miss_q, fetch_miss_d;
`endif

    logic [ADDR_WIDTH-1:0] tgt_addr;
    logic                  tgt_valid;
    logic                  word_start;
    logic                  word_end;
    logic                  fetch_trig;
    logic                  swap;

    vram_fetch_addr #(
        .DATA_WIDTH              (DATA_WIDTH),
        .ADDR_WIDTH              (ADDR_WIDTH),
        .BITS_PER_MEMORY_PIXEL_X (BITS_PER_MEMORY_PIXEL_X),
        .BITS_PER_MEMORY_PIXEL_Y (BITS_PER_MEMORY_PIXEL_Y),
        .WORDS_PER_ROW           (WORDS_PER_ROW),
        .ROWS                    (ROWS),
        .FB_BASE                 (FB_BASE),
        .V_TOTAL                 (V_TOTAL)
    ) u_fetch_addr (
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .tgt_addr   (tgt_addr),
        .tgt_valid  (tgt_valid),
        .word_start (word_start),
        .word_end   (word_end)
    );

    assign fetch_trig = word_start && tgt_valid;
    assign swap       = word_end && tgt_valid;

    // Next-state, RAM-port, CPU-response and display-buffer logic. The trigger is
    // looked at directly in IDLE so a CPU request arriving on the trigger cycle
    // still loses to the display read.
    always_comb begin
        state_d        = state_q;
        mem_addr_d     = mem_addr_q;
        mem_we_d       = 1'b0;
        mem_wdata_d    = mem_wdata_q;
        op_we_d        = op_we_q;
        cpu_ack_d      = 1'b0;
        cpu_rdata_d    = cpu_rdata_q;
        shadow_d       = shadow_q;
        shadow_valid_d = shadow_valid_q;
        disp_pending_d = disp_pending_q || fetch_trig;
        disp_addr_d    = fetch_trig ? tgt_addr : disp_addr_q;
        pixel_word_d   = pixel_word_q;
`ifdef VRAM_ARB_MISS_DETECT_EN
        fetch_miss_d   = fetch_miss_q;
`endif

        case (state_q)
            IDLE: begin
                if (disp_pending_q || fetch_trig) begin
                    state_d    = DISP_RD;
                    mem_addr_d = fetch_trig ? tgt_addr : disp_addr_q;
                end else if (bus.cpu_req && !cpu_ack_q) begin
                    state_d    = CPU_ACC;
                    mem_addr_d = bus.cpu_addr;
                    mem_we_d   = bus.cpu_we;
                    op_we_d    = bus.cpu_we;
                    if (bus.cpu_we) begin
                        mem_wdata_d = bus.cpu_wdata;
                    end
                end
            end
            DISP_RD: begin
                state_d = DISP_CAP;
            end
            DISP_CAP: begin
                state_d        = IDLE;
                shadow_d       = bus.mem_rdata;
                shadow_valid_d = 1'b1;
                disp_pending_d = fetch_trig;
            end
            CPU_ACC: begin
                state_d = CPU_CAP;
            end
            CPU_CAP: begin
                state_d   = IDLE;
                cpu_ack_d = 1'b1;
                if (!op_we_q) begin
                    cpu_rdata_d = bus.mem_rdata;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (swap) begin
            shadow_valid_d = 1'b0;
            if (shadow_valid_q) begin
                pixel_word_d = shadow_q;
            end
`ifdef VRAM_ARB_MISS_DETECT_EN
            else begin
                fetch_miss_d = 1'b1;
            end
`endif
        end
    end

    // State and datapath registers; reset abandons any access in flight.
    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q        <= IDLE;
            mem_addr_q     <= '0;
            mem_we_q       <= 1'b0;
            mem_wdata_q    <= '0;
            op_we_q        <= 1'b0;
            cpu_ack_q      <= 1'b0;
            cpu_rdata_q    <= '0;
            shadow_q       <= '0;
            shadow_valid_q <= 1'b0;
            disp_pending_q <= 1'b0;
            disp_addr_q    <= '0;
            pixel_word_q   <= '0;
        end else begin
            state_q        <= state_d;
            mem_addr_q     <= mem_addr_d;
            mem_we_q       <= mem_we_d;
            mem_wdata_q    <= mem_wdata_d;
            op_we_q        <= op_we_d;
            cpu_ack_q      <= cpu_ack_d;
            cpu_rdata_q    <= cpu_rdata_d;
            shadow_q       <= shadow_d;
            shadow_valid_q <= shadow_valid_d;
            disp_pending_q <= disp_pending_d;
            disp_addr_q    <= disp_addr_d;
            pixel_word_q   <= pixel_word_d;
        end
    end

`ifdef VRAM_ARB_MISS_DETECT_EN
    // Sticky underrun flag, cleared only by reset.
    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            fetch_miss_q <= 1'b0;
        end else begin
            fetch_miss_q <= fetch_miss_d;
        end
    end

    assign fetch_miss = fetch_miss_q;
`else
    assign fetch_miss = 1'b0;
`endif

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign pixel_word    = pixel_word_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - directed self-checking bench for vram_arbiter
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic [15:0] pixel_word;
    logic        fetch_miss;
    logic        do_fill;

    int n_checks = 0;
    int n_errors = 0;

`ifdef VRAM_ARB_MISS_DETECT_EN
    localparam logic EXP_MISS = 1'b1;
`else
    localparam logic EXP_MISS = 1'b0;
`endif

    vram_arbiter_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) bus ();

    vram_arbiter dut (
        .CLK_50     (clk),
        .RESET_N    (rst_n),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .bus        (bus),
        .pixel_word (pixel_word),
        .fetch_miss (fetch_miss)
    );

    always #5 clk = ~clk;

    // synchronous single-port RAM, one-cycle read latency
    logic [15:0] ram [0:255];
    always @(posedge clk) begin
        if (do_fill) begin
            for (int a = 0; a < 256; a++) ram[a] <= 16'(a);
        end else if (bus.mem_we) begin
            ram[bus.mem_addr] <= bus.mem_wdata;
        end
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cpu_drive(input logic req, input logic we, input logic [7:0] addr,
                             input logic [15:0] wdata);
        bus.cpu_req   = req;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ack"},       32'(bus.cpu_ack),   32'd0);
        check({tag, "_rdata"},     32'(bus.cpu_rdata), 32'd0);
        check({tag, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
        check({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
        check({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
        check({tag, "_pixel"},     32'(pixel_word),    32'd0);
        check({tag, "_miss"},      32'(fetch_miss),    32'd0);
    endtask

    // sweep x = 0..515 on line y; exp < 0 skips that check
    task automatic run_line(input int y, input int exp0, input int exp256);
        for (int x = 0; x < 516; x++) begin
            @(negedge clk);
            if (x == 0 && exp0 >= 0)
                check($sformatf("pw_y%0d_x0", y), 32'(pixel_word), 32'(exp0));
            if (x == 256)
                check($sformatf("pw_y%0d_x256", y), 32'(pixel_word), 32'(exp256));
            pixel_x = 10'(x);
            pixel_y = 10'(y);
        end
    endtask

    // ack spacing / read-data monitor for the held-request frame
    logic mon_en = 1'b0;
    int   mon_cyc = 0;
    int   last_ack = -1;
    int   min_gap = 1000;
    int   max_gap = 0;
    int   n_acks = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            mon_cyc++;
            if (bus.cpu_ack) begin
                check("frame_rdata", 32'(bus.cpu_rdata), 32'h30);
                if (last_ack >= 0) begin
                    if (mon_cyc - last_ack < min_gap) min_gap = mon_cyc - last_ack;
                    if (mon_cyc - last_ack > max_gap) max_gap = mon_cyc - last_ack;
                end
                last_ack = mon_cyc;
                n_acks++;
            end
        end
    end

    int stray_acks;

    initial begin
        rst_n   = 1'b0;
        do_fill = 1'b1;
        pixel_x = 10'd600;
        pixel_y = 10'd0;
        cpu_drive(1'b0, 1'b0, 8'h00, 16'h0000);
        repeat (3) @(negedge clk);
        check_reset_values("por");
        do_fill = 1'b0;
        rst_n   = 1'b1;
        repeat (2) @(negedge clk);

        // uncontended write then read of address 0x05
        cpu_drive(1'b1, 1'b1, 8'h05, 16'hA5C3);
        @(negedge clk);
        check("wr_we_acc",    32'(bus.mem_we),    32'd1);
        check("wr_addr",      32'(bus.mem_addr),  32'h05);
        check("wr_wdata",     32'(bus.mem_wdata), 32'hA5C3);
        @(negedge clk);
        check("wr_we_cap",    32'(bus.mem_we),    32'd0);
        check("wr_ack_early", 32'(bus.cpu_ack),   32'd0);
        @(negedge clk);
        check("wr_ack",       32'(bus.cpu_ack),   32'd1);
        cpu_drive(1'b0, 1'b0, 8'h00, 16'h0000);
        @(negedge clk);
        check("wr_ack_pulse", 32'(bus.cpu_ack),   32'd0);
        cpu_drive(1'b1, 1'b0, 8'h05, 16'h0000);
        @(negedge clk);
        check("rd_we",        32'(bus.mem_we),    32'd0);
        check("rd_addr",      32'(bus.mem_addr),  32'h05);
        @(negedge clk);
        @(negedge clk);
        check("rd_ack",       32'(bus.cpu_ack),   32'd1);
        check("rd_data",      32'(bus.cpu_rdata), 32'hA5C3);
        cpu_drive(1'b0, 1'b0, 8'h00, 16'h0000);
        repeat (2) @(negedge clk);

        // display scan with a CPU read request held high throughout
        cpu_drive(1'b1, 1'b0, 8'h30, 16'h0000);
        mon_en = 1'b1;
        run_line(382, -1, 47);
        run_line(383, 46, 47);
        run_line(384, 47, 47);
        run_line(524, 47, 47);
        run_line(0,   0,  1);
        run_line(15,  0,  1);
        run_line(16,  2,  3);
        @(negedge clk);
        mon_en  = 1'b0;
        pixel_x = 10'd600;
        cpu_drive(1'b0, 1'b0, 8'h00, 16'h0000);
        check("frame_min_gap",  32'(min_gap),       32'd4);
        check("frame_max_gap",  32'(max_gap <= 7),  32'd1);
        check("frame_acks",     32'(n_acks > 800),  32'd1);
        check("frame_no_miss",  32'(fetch_miss),    32'd0);
        repeat (8) @(negedge clk);

        // CPU request on the same cycle as the fetch trigger at x=0
        pixel_y = 10'd0;
        for (int x = 0; x <= 300; x++) begin
            @(negedge clk);
            if (x == 1) check("ct_disp_first", 32'(bus.mem_addr), 32'h01);
            if (x == 3) check("ct_ack_n3",     32'(bus.cpu_ack),  32'd0);
            if (x == 4) check("ct_cpu_addr",   32'(bus.mem_addr), 32'h30);
            if (x == 5) check("ct_ack_n5",     32'(bus.cpu_ack),  32'd0);
            if (x == 6) begin
                check("ct_ack_n6",   32'(bus.cpu_ack),   32'd1);
                check("ct_rdata",    32'(bus.cpu_rdata), 32'h30);
                cpu_drive(1'b0, 1'b0, 8'h00, 16'h0000);
            end
            if (x == 7)   check("ct_ack_n7", 32'(bus.cpu_ack), 32'd0);
            if (x == 256) check("ct_pixel",  32'(pixel_word),  32'd1);
            if (x == 0)   cpu_drive(1'b1, 1'b0, 8'h30, 16'h0000);
            pixel_x = 10'(x);
        end

        // reset pulse at x=250 of line 0 with a CPU write in flight
        stray_acks = 0;
        for (int x = 0; x <= 270; x++) begin
            @(negedge clk);
            if (x == 249) begin
                check("rs_pixel_before", 32'(pixel_word), 32'd1);
                cpu_drive(1'b1, 1'b1, 8'h40, 16'hBEEF);
            end
            if (x == 250) begin
                check("rs_we_in_flight", 32'(bus.mem_we), 32'd1);
                rst_n = 1'b0;
                cpu_drive(1'b0, 1'b0, 8'h00, 16'h0000);
                #1;
                check_reset_values("mid");
            end
            if (x == 252) rst_n = 1'b1;
            if (x > 250 && bus.cpu_ack) stray_acks++;
            if (x == 256) begin
                check("rs_pixel_hold", 32'(pixel_word), 32'd0);
                check("rs_miss",       32'(fetch_miss), 32'(EXP_MISS));
            end
            pixel_x = 10'(x);
        end
        check("rs_no_stray_ack", 32'(stray_acks), 32'd0);
        pixel_x = 10'd600;
        repeat (4) @(negedge clk);

        // fresh request after reset; the abandoned write must not have landed
        cpu_drive(1'b1, 1'b0, 8'h40, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        check("post_ack_early", 32'(bus.cpu_ack),   32'd0);
        @(negedge clk);
        check("post_ack",       32'(bus.cpu_ack),   32'd1);
        check("post_rdata",     32'(bus.cpu_rdata), 32'h40);
        check("post_miss",      32'(fetch_miss),    32'(EXP_MISS));
        cpu_drive(1'b0, 1'b0, 8'h00, 16'h0000);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
